button_conditioner: RTL and testbench

Front-end input stage that sits directly upstream of the 8-bit logic processor top level. It takes the raw push-button pins (Reset, LoadA, LoadB, Execute), then synchronises, polarity-corrects and debounces them. It presents clean active-high levels plus one-cycle press and release pulses. The processor's control unit and LED debug bus consume these in place of raw pins. Each channel is independent; there is no cross-channel coupling.

---
 rtl/button_conditioner_if.sv | 25 ++
 rtl/button_conditioner.sv | 122 ++++++++++++
 tb/tb_button_conditioner.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw pins in, conditioned levels and
// edge pulses out. The master side drives the pins; the slave side is the
// conditioner.
interface button_conditioner_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] Btn_In;
  logic [NUM_BTN-1:0] Level_Out;
  logic [NUM_BTN-1:0] Press_Pulse;
  logic [NUM_BTN-1:0] Release_Pulse;

  modport master (
    output Btn_In,
    input  Level_Out,
    input  Press_Pulse,
    input  Release_Pulse
  );

  modport slave (
    input  Btn_In,
    output Level_Out,
    output Press_Pulse,
    output Release_Pulse
  );
endinterface

// File: rtl/button_conditioner.sv
// Push-button front end: polarity correction, two-flop synchroniser,
// per-channel debounce counter and registered press/release pulses.
// Optional auto-repeat of Press_Pulse while held: define BTN_REPEAT_EN.
//
// Per-channel debounce state is implied by the counter:
//   state    | meaning
//   STABLE   | cnt == 0, synchronised pin equals accepted level
//   COUNTING | synchronised pin differs, cnt counts stable cycles
module button_conditioner #(
  parameter int                 NUM_BTN         = 4,
  parameter logic [NUM_BTN-1:0] INVERT_MASK     = 4'b1001,
  parameter int                 DEBOUNCE_CYCLES = 50000,
  parameter int                 CNT_W           = 16,
  parameter int                 REPEAT_DELAY    = 25000000,
  parameter int                 REPEAT_PERIOD   = 5000000
) (
  input  logic Clk,
  input  logic Reset,
  button_conditioner_if.slave btn
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject timing values the counters cannot represent.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_conditioner: illegal timing parameters");
  end

  logic [NUM_BTN-1:0] s1_q, s1_d;
  logic [NUM_BTN-1:0] s2_q, s2_d;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];

`ifdef BTN_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_TERM  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_TERM = REP_W'(REPEAT_PERIOD - 1);

  // rep_first_q selects the initial hold delay versus the steady period.
  logic [REP_W-1:0]   rep_cnt_q [NUM_BTN];
  logic [REP_W-1:0]   rep_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] rep_first_q, rep_first_d;
`endif

  // Next-state: sync shift, debounce counting, pulse generation.
  always_comb begin
    s1_d      = btn.Btn_In ^ INVERT_MASK;
    s2_d      = s1_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
`ifdef BTN_REPEAT_EN
    rep_first_d = rep_first_q;
`endif
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TERM) begin
        cnt_d[i]     = '0;
        level_d[i]   = s2_q[i];
        press_d[i]   = s2_q[i];
        release_d[i] = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
`ifdef BTN_REPEAT_EN
      // Hold timer runs only across cycles where the level stays high;
      // a release accepted this cycle takes precedence over a repeat.
      rep_cnt_d[i] = rep_cnt_q[i];
      if (!level_q[i] || !level_d[i]) begin
        rep_cnt_d[i]   = '0;
        rep_first_d[i] = 1'b1;
      end else if (rep_first_q[i] ? (rep_cnt_q[i] == REP_DELAY_TERM)
                                  : (rep_cnt_q[i] == REP_PERIOD_TERM)) begin
        rep_cnt_d[i]   = '0;
        rep_first_d[i] = 1'b0;
        press_d[i]     = 1'b1;
      end else begin
        rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
      end
`endif
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
`ifdef BTN_REPEAT_EN
      rep_first_q <= '1;
      for (int i = 0; i < NUM_BTN; i++) rep_cnt_q[i] <= '0;
`endif
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
`ifdef BTN_REPEAT_EN
      rep_first_q <= rep_first_d;
      for (int i = 0; i < NUM_BTN; i++) rep_cnt_q[i] <= rep_cnt_d[i];
`endif
    end
  end

  assign btn.Level_Out     = level_q;
  assign btn.Press_Pulse   = press_q;
  assign btn.Release_Pulse = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5. A window-based reference model runs every cycle; table
// vectors and hand sequences add targeted timing checks.
module tb_button_conditioner;
  localparam int         NB   = 4;
  localparam logic [3:0] MASK = 4'b1001;
  localparam int         DB   = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 5;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   chk_en = 1'b0;

  button_conditioner_if #(.NUM_BTN(NB)) bif ();

  button_conditioner #(
    .NUM_BTN(NB), .INVERT_MASK(MASK), .DEBOUNCE_CYCLES(DB), .CNT_W(16),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .btn(bif)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: a new level is accepted when the last DB synchronised
  // samples (pin values taken 2..DB+1 edges ago) all differ from the level.
  logic [DB:0]   m_hist [NB];
  logic [NB-1:0] m_level, m_press, m_rel;
  int            m_hold [NB];

  always @(posedge Clk) begin
    logic [NB-1:0] p, nl, np, nr;
    logic          acc;
    int            h;
    p = bif.Btn_In ^ MASK;
    if (!Reset) begin
      for (int i = 0; i < NB; i++) begin
        m_hist[i] <= '0;
        m_hold[i] <= 0;
      end
      m_level <= '0;
      m_press <= '0;
      m_rel   <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        acc   = m_level[i] ? (m_hist[i][DB:1] == '0) : (&m_hist[i][DB:1]);
        nl[i] = acc ? ~m_level[i] : m_level[i];
        np[i] = acc & nl[i];
        nr[i] = acc & ~nl[i];
        h = (!nl[i] || acc) ? 0 : m_hold[i] + 1;
`ifdef BTN_REPEAT_EN
        if (nl[i] && !acc && h >= RD && ((h - RD) % RP) == 0) np[i] = 1'b1;
`endif
        m_hold[i] <= h;
        m_hist[i] <= {m_hist[i][DB-1:0], p[i]};
      end
      m_level <= nl;
      m_press <= np;
      m_rel   <= nr;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("model_level", 32'(bif.Level_Out), 32'(m_level));
      chk("model_press", 32'(bif.Press_Pulse), 32'(m_press));
      chk("model_release", 32'(bif.Release_Pulse), 32'(m_rel));
      chk("press_release_excl", 32'(bif.Press_Pulse & bif.Release_Pulse), 32'd0);
    end
  end

  typedef struct {
    logic [3:0] btn;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rls;
  } vec_t;

  initial begin
    vec_t       tbl [6];
    logic [3:0] pacc, racc, lacc;
    logic [31:0] pmask, pmask_exp;
    int         first_t, npress;

    tbl[0] = '{btn: 4'b1001, lvl: 4'b0000, prs: 4'b0000, rls: 4'b0000};
    tbl[1] = '{btn: 4'b1101, lvl: 4'b0100, prs: 4'b0100, rls: 4'b0000};
    tbl[2] = '{btn: 4'b0111, lvl: 4'b1110, prs: 4'b1010, rls: 4'b0000};
    tbl[3] = '{btn: 4'b1000, lvl: 4'b0001, prs: 4'b0001, rls: 4'b1110};
    tbl[4] = '{btn: 4'b0110, lvl: 4'b1111, prs: 4'b1110, rls: 4'b0000};
    tbl[5] = '{btn: 4'b1001, lvl: 4'b0000, prs: 4'b0000, rls: 4'b1111};

    bif.Btn_In = MASK;
    Reset = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;
    chk_en = 1'b1;
    chk("reset_level", 32'(bif.Level_Out), 32'd0);
    chk("reset_press", 32'(bif.Press_Pulse), 32'd0);
    chk("reset_release", 32'(bif.Release_Pulse), 32'd0);

    // Table: steady input patterns held long enough to settle.
    for (int v = 0; v < 6; v++) begin
      bif.Btn_In = tbl[v].btn;
      pacc = '0;
      racc = '0;
      repeat (10) begin
        tick();
        pacc |= bif.Press_Pulse;
        racc |= bif.Release_Pulse;
      end
      chk($sformatf("tbl%0d_level", v), 32'(bif.Level_Out), 32'(tbl[v].lvl));
      chk($sformatf("tbl%0d_press", v), 32'(pacc), 32'(tbl[v].prs));
      chk($sformatf("tbl%0d_release", v), 32'(racc), 32'(tbl[v].rls));
    end

    // Clean step on channel 2: level and pulse exactly 6 edges after sampling.
    bif.Btn_In = 4'b1101;
    lacc = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      lacc |= bif.Level_Out | bif.Press_Pulse;
    end
    chk("step_early", 32'(lacc), 32'd0);
    tick();
    chk("step_level", 32'(bif.Level_Out), 32'b0100);
    chk("step_press", 32'(bif.Press_Pulse), 32'b0100);
    tick();
    chk("step_press_width", 32'(bif.Press_Pulse), 32'd0);
    bif.Btn_In = 4'b1001;
    repeat (8) tick();

    // Channel 0 (active-low pin) 3-cycle glitch must be filtered.
    lacc = '0;
    pacc = '0;
    racc = '0;
    for (int k = 0; k < 35; k++) begin
      if (k == 20) bif.Btn_In[0] = 1'b0;
      if (k == 23) bif.Btn_In[0] = 1'b1;
      tick();
      lacc |= bif.Level_Out;
      pacc |= bif.Press_Pulse;
      racc |= bif.Release_Pulse;
    end
    chk("glitch_level", 32'(lacc), 32'd0);
    chk("glitch_press", 32'(pacc), 32'd0);
    chk("glitch_release", 32'(racc), 32'd0);

    // Channel 1 bounce 1,0,1,0 then final 1 held.
    npress = 0;
    first_t = -1;
    bif.Btn_In[1] = 1'b1; tick(); if (bif.Press_Pulse[1]) npress++;
    bif.Btn_In[1] = 1'b0; tick(); if (bif.Press_Pulse[1]) npress++;
    bif.Btn_In[1] = 1'b1; tick(); if (bif.Press_Pulse[1]) npress++;
    bif.Btn_In[1] = 1'b0; tick(); if (bif.Press_Pulse[1]) npress++;
    bif.Btn_In[1] = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (bif.Press_Pulse[1]) begin
        npress++;
        if (first_t < 0) first_t = t;
      end
    end
    chk("bounce_press_count", 32'(npress), 32'd1);
    chk("bounce_press_time", 32'(first_t), 32'd6);
    chk("bounce_level", 32'(bif.Level_Out), 32'b0010);

    // Channels 3 and 1 released together.
    bif.Btn_In[3] = 1'b0;
    repeat (8) tick();
    chk("pre_release_level", 32'(bif.Level_Out), 32'b1010);
    bif.Btn_In[3] = 1'b1;
    bif.Btn_In[1] = 1'b0;
    racc = '0;
    lacc = '1;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (racc == '0 && bif.Release_Pulse != '0) begin
        racc = bif.Release_Pulse;
        lacc = bif.Level_Out;
      end
    end
    chk("dual_release", 32'(racc), 32'b1010);
    chk("dual_release_level", 32'(lacc), 32'd0);

    // Reset in mid-count on channel 2 discards the partial count.
    bif.Btn_In = 4'b1101;
    repeat (4) tick();
    Reset = 1'b0;
    tick();
    chk("midreset_level", 32'(bif.Level_Out), 32'd0);
    chk("midreset_pulses", 32'(bif.Press_Pulse | bif.Release_Pulse), 32'd0);
    Reset = 1'b1;
    lacc = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      lacc |= bif.Level_Out;
    end
    chk("postreset_early", 32'(lacc), 32'd0);
    tick();
    chk("postreset_level", 32'(bif.Level_Out), 32'b0100);
    chk("postreset_press", 32'(bif.Press_Pulse), 32'b0100);

    // Long hold on channel 2: repeat pulses only when the feature is built in.
    pmask = '0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (bif.Press_Pulse[2]) pmask[t] = 1'b1;
    end
`ifdef BTN_REPEAT_EN
    pmask_exp = (32'd1 << 10) | (32'd1 << 15) | (32'd1 << 20) | (32'd1 << 25) | (32'd1 << 30);
`else
    pmask_exp = 32'd0;
`endif
    chk("hold_press_times", pmask, pmask_exp);
    bif.Btn_In = 4'b1001;
    pacc = '0;
    racc = '0;
    repeat (25) begin
      tick();
      pacc |= bif.Press_Pulse;
      racc |= bif.Release_Pulse;
    end
    chk("after_release_press", 32'(pacc), 32'd0);
    chk("after_release_rel", 32'(racc), 32'b0100);

    // Randomised segments with varying bounce density and occasional reset.
    for (int seg = 0; seg < 30; seg++) begin
      int lim;
      case ($urandom_range(0, 2))
        0:       lim = 1;
        1:       lim = 7;
        default: lim = 31;
      endcase
      for (int c = 0; c < 100; c++) begin
        for (int i = 0; i < NB; i++)
          if ($urandom_range(0, lim) == 0) bif.Btn_In[i] = ~bif.Btn_In[i];
        Reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
        tick();
      end
    end
    Reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
